// File: rtl/scc_pkg.sv
// Shared fetch-path types and constants for the prefetch queue.
package scc_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [5:0] OPC_BRANCH_PREFIX = 6'b110000;
  localparam logic [6:0] OPC_B             = {OPC_BRANCH_PREFIX, 1'b0};
  localparam logic [6:0] OPC_BCOND         = {OPC_BRANCH_PREFIX, 1'b1};

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Both branch flavours share the 6-bit prefix; naming them keeps decode readable.
  function automatic logic is_branch(input logic [INSTR_W-1:0] instr);
    return (instr[31:25] == OPC_B) || (instr[31:25] == OPC_BCOND);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// In-order FIFO with flush, registered write and combinational head read.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; the consumer qualifies the head with empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited issue, in-order buffering, redirect flush.
module prefetch_queue
  import scc_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_branch
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      target_pc;
  logic [OS_W-1:0]  outstanding;
  logic [OS_W-1:0]  discard;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] credits_used;
  logic             issue;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign target_pc    = redirect_pc & ~32'h0000_0003;
  assign credits_used = SUM_W'(count) + SUM_W'(outstanding);

  // Every in-flight request owns a FIFO slot, so a kept response always fits.
  assign imem_req  = !reset && !redirect
                  && (credits_used < SUM_W'(DEPTH))
                  && (outstanding < OS_W'(MAX_OUTSTANDING));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req && imem_gnt;

  assign push       = imem_rvalid && !redirect && (discard == '0);
  assign push_entry = '{instr: imem_rdata, pc: resp_pc};

  assign out_valid     = !fifo_empty && !redirect;
  assign pop           = out_valid && out_ready;
  assign out_instr     = fifo_empty ? '0 : head_entry.instr;
  assign out_pc        = fifo_empty ? '0 : head_entry.pc;
  assign out_is_branch = !fifo_empty && is_branch(head_entry.instr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      // Everything still in flight is stale; a response landing now is one of them.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      outstanding <= outstanding - OS_W'(imem_rvalid);
      discard     <= discard + outstanding - OS_W'(imem_rvalid);
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'(PC_STEP);
      outstanding <= outstanding + OS_W'(issue) - OS_W'(imem_rvalid);
      if (imem_rvalid && discard != '0) discard <= discard - 1'b1;
      if (push) resp_pc <= resp_pc + 32'(PC_STEP);
    end
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head_entry),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench: memory model plus scoreboard, stream/stall/redirect/reset scenarios.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_branch;

  always #5 clk = ~clk;

  prefetch_queue #(
    .DEPTH(4),
    .MAX_OUTSTANDING(2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_is_branch(out_is_branch)
  );

  typedef struct { logic [31:0] data; int due; } resp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] pc; int cyc; } dlv_t;
  typedef struct {
    logic [31:0] redirect_pc;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic        exp_branch;
  } vec_t;

  resp_t       pend[$];
  exp_t        sb[$];
  dlv_t        dlv[$];
  logic [31:0] iss[$];
  logic [31:0] over_mem [logic [31:0]];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int unanswered = 0;
  int max_unanswered = 0;
  int first_grant_cyc = -1;
  int first_valid_cyc = -1;

  bit          gnt_ctl = 1'b1;
  bit          ready_ctl = 1'b1;
  bit          redir_ctl = 1'b0;
  int          lat_ctl = 1;
  logic [31:0] redir_pc_ctl = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 time unit later, log transactions.
  task automatic tick();
    logic [31:0] data;
    exp_t        e;
    @(negedge clk);
    cyc++;
    redirect    = redir_ctl;
    redirect_pc = redir_pc_ctl;
    out_ready   = ready_ctl;
    imem_gnt    = gnt_ctl;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].data;
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (imem_rvalid) unanswered--;
    if (redirect) begin
      sb.delete();
      dlv.delete();
      iss.delete();
    end
    if (imem_req && imem_gnt) begin
      data = over_mem.exists(imem_addr) ? over_mem[imem_addr] : (imem_addr | 32'hA000_0000);
      pend.push_back('{data: data, due: cyc + lat_ctl});
      sb.push_back('{pc: imem_addr, instr: data});
      iss.push_back(imem_addr);
      unanswered++;
      if (unanswered > max_unanswered) max_unanswered = unanswered;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      $display("issue   cyc=%0d addr=%08h", cyc, imem_addr);
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) begin
      $display("deliver cyc=%0d pc=%08h instr=%08h br=%0b", cyc, out_pc, out_instr, out_is_branch);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual_pc=%08h required=no_delivery", out_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        check("sb_branch", 32'(out_is_branch), 32'(e.instr[31:26] == 6'b110000));
      end
      dlv.push_back('{pc: out_pc, cyc: cyc});
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    out_ready   = 1'b0;
    redir_ctl   = 1'b0;
    pend.delete();
    sb.delete();
    dlv.delete();
    iss.delete();
    unanswered      = 0;
    max_unanswered  = 0;
    first_grant_cyc = -1;
    first_valid_cyc = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    vecs[0] = '{32'h0000_0200, 32'hC200_0010, 32'h0000_0200, 1'b1};
    vecs[1] = '{32'h0000_0303, 32'hC000_FFFC, 32'h0000_0300, 1'b1};
    vecs[2] = '{32'h0000_0400, 32'h1200_0000, 32'h0000_0400, 1'b0};
    vecs[3] = '{32'h0000_0507, 32'hC3FF_FFFF, 32'h0000_0504, 1'b1};
    vecs[4] = '{32'h0000_0600, 32'hC400_0000, 32'h0000_0600, 1'b0};
    vecs[5] = '{32'h0000_0700, 32'h8000_0001, 32'h0000_0700, 1'b0};

    // Reset state
    @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_branch", 32'(out_is_branch), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    do_reset();

    // Streaming at full throughput
    gnt_ctl = 1'b1; lat_ctl = 1; ready_ctl = 1'b1;
    run(10);
    check("p1_latency", 32'(first_valid_cyc - first_grant_cyc), 32'd2);
    check("p1_count", 32'(dlv.size() >= 4), 32'd1);
    if (dlv.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("p1_pc", dlv[i].pc, 32'(4 * i));
        check("p1_cycle", 32'(dlv[i].cyc - dlv[0].cyc), 32'(i));
      end
    end

    // Consumer stalled: queue fills, then drains and fetching resumes
    do_reset();
    ready_ctl = 1'b0;
    run(10);
    check("p2_req_low", 32'(imem_req), 32'd0);
    check("p2_held", 32'(iss.size()), 32'd4);
    check("p2_head_valid", 32'(out_valid), 32'd1);
    check("p2_head_pc", out_pc, 32'h0);
    ready_ctl = 1'b1;
    run(10);
    check("p2_drain_count", 32'(dlv.size() >= 4 && iss.size() >= 5), 32'd1);
    if (dlv.size() >= 4 && iss.size() >= 5) begin
      for (int i = 0; i < 4; i++) check("p2_drain_pc", dlv[i].pc, 32'(4 * i));
      check("p2_resume_addr", iss[4], 32'h10);
    end

    // Slow memory: outstanding limit honoured, order preserved
    do_reset();
    lat_ctl = 3; ready_ctl = 1'b1;
    run(30);
    check("p3_max_outstanding", 32'(max_unanswered), 32'd2);
    check("p3_count", 32'(dlv.size() >= 6), 32'd1);
    if (dlv.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("p3_pc", dlv[i].pc, 32'(4 * i));
    end

    // Redirect with two in flight and two buffered
    do_reset();
    lat_ctl = 3; ready_ctl = 1'b0;
    n = 0;
    while (!(unanswered == 2 && (iss.size() - unanswered - dlv.size()) == 2) && n < 30) begin
      tick();
      n++;
    end
    check("p4_setup", 32'(n < 30), 32'd1);
    redir_ctl = 1'b1; redir_pc_ctl = 32'h0000_0103;
    tick();
    check("p4_redirect_valid", 32'(out_valid), 32'd0);
    check("p4_redirect_req", 32'(imem_req), 32'd0);
    redir_ctl = 1'b0; ready_ctl = 1'b1;
    run(15);
    check("p4_count", 32'(dlv.size() >= 2 && iss.size() >= 1), 32'd1);
    if (dlv.size() >= 2 && iss.size() >= 1) begin
      check("p4_first_issue", iss[0], 32'h100);
      check("p4_first_pc", dlv[0].pc, 32'h100);
      check("p4_second_pc", dlv[1].pc, 32'h104);
    end

    // Redirect coinciding with a response while another is in flight
    do_reset();
    lat_ctl = 2; ready_ctl = 1'b1;
    n = 0;
    while (!(unanswered == 2 && pend.size() > 0 && pend[0].due == cyc + 1) && n < 20) begin
      tick();
      n++;
    end
    check("p5_setup", 32'(n < 20), 32'd1);
    redir_ctl = 1'b1; redir_pc_ctl = 32'h0000_0040;
    tick();
    check("p5_rvalid_in_redirect", 32'(imem_rvalid), 32'd1);
    redir_ctl = 1'b0;
    run(12);
    check("p5_discard", 32'(dut.discard), 32'd0);
    check("p5_count", 32'(dlv.size() >= 3 && iss.size() >= 1), 32'd1);
    if (dlv.size() >= 3 && iss.size() >= 1) begin
      check("p5_first_issue", iss[0], 32'h40);
      check("p5_first_pc", dlv[0].pc, 32'h40);
      check("p5_third_pc", dlv[2].pc, 32'h48);
    end

    // Table: redirect targets and predecode of the head word
    do_reset();
    lat_ctl = 1; ready_ctl = 1'b0;
    for (int v = 0; v < 6; v++) begin
      over_mem[vecs[v].exp_pc] = vecs[v].word;
      redir_ctl = 1'b1; redir_pc_ctl = vecs[v].redirect_pc;
      tick();
      redir_ctl = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      check("tbl_valid", 32'(out_valid), 32'd1);
      check("tbl_pc", out_pc, vecs[v].exp_pc);
      check("tbl_instr", out_instr, vecs[v].word);
      check("tbl_branch", 32'(out_is_branch), 32'(vecs[v].exp_branch));
    end
    over_mem.delete();

    // Asynchronous reset mid-burst
    do_reset();
    lat_ctl = 1; ready_ctl = 1'b1;
    run(6);
    check("p7_pre_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("p7_valid", 32'(out_valid), 32'd0);
    check("p7_pc", out_pc, 32'h0);
    check("p7_instr", out_instr, 32'h0);
    check("p7_branch", 32'(out_is_branch), 32'd0);
    check("p7_req", 32'(imem_req), 32'd0);
    do_reset();
    run(8);
    check("p7_count", 32'(dlv.size() >= 1 && iss.size() >= 1), 32'd1);
    if (dlv.size() >= 1 && iss.size() >= 1) begin
      check("p7_restart_addr", iss[0], 32'h0);
      check("p7_restart_pc", dlv[0].pc, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
